demux4_dispatcher: RTL
======================

Name: demux4_dispatcher

Overview:
- Round-robin sequencer that feeds a 1-to-4 demultiplexer from a single valid/ready input stream.
- Holds one item at a time and commits it to one enabled destination; that commitment drives the demux select.
- Keeps the item on the chosen output until that output accepts it, then moves to the next destination.
- Sits between a single producer and four consumers, for example four lanes of the CH03 demux datapath.

Parameters:
- W, 8: data width in bits of the input item and of y_data.
- CW, 16: width of the transfer counter xfer_count.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  4  destination enable mask; bit i set means y_i may be selected.
- in_valid  in  1  producer has an item.
- in_data  in  W  producer item.
- in_ready  out  1  dispatcher accepts in_data this cycle.
- y_valid  out  4  one-hot or zero; bit sel is asserted while the held item is offered.
- y_ready  in  4  per-destination accept.
- y_data  out  W  held item, broadcast to all destinations; only the y_valid bit is meaningful.
- sel  out  2  committed destination index; drives the demux select.
- busy  out  1  an item is held (state is not IDLE).
- xfer_count  out  CW  completed transfers, wraps modulo 2^CW.

Behaviour:
- Registers: state, ptr (2-bit next-preferred index), sel, buf_data (W bits), xfer_count.
- Reset (sampled on clk while reset=1): state=IDLE, ptr=0, sel=0, buf_data=0, xfer_count=0.
- Outputs during reset: y_valid=0, in_ready=0, busy=0.
- pick(p, m): first index i in cyclic order p, p+1, p+2, p+3 (mod 4) with m[i]=1. Flag none when m=0.
- States:
  - IDLE: buffer empty, y_valid=0, in_ready=1. On in_valid: load buf_data. If pick(ptr, en) finds an index, sel := that index and go to SEND. If en=0, go to WAIT_EN.
  - WAIT_EN: item held, y_valid=0, in_ready=0. Re-evaluate pick(ptr, en) every cycle. When an index is found, sel := it and go to SEND the next cycle.
  - SEND: y_valid = onehot(sel), y_data = buf_data, busy=1.
    - fire = y_ready[sel]. On fire: ptr := sel+1 mod 4, xfer_count += 1.
    - On fire with in_valid=0: go to IDLE.
- in_ready = (state==IDLE) or (state==SEND and y_ready[sel]), gated by not reset. The combinational path from y_ready to in_ready is intentional and gives 1 item/cycle throughput.
- Simultaneous fire and load in SEND: buf_data := in_data. The new sel comes from pick(sel+1, en). If an index is found, stay in SEND, so y_valid moves to the new sel the next cycle. If en=0, go to WAIT_EN.
- Latency: an item accepted in cycle t is offered (y_valid) in cycle t+1 when en is non-zero. Minimum occupancy is 1 cycle per item.
- Commitment is sticky:
  - sel and buf_data do not change while in SEND without fire.
  - Clearing en[sel] in SEND does not withdraw or redirect the item.
  - y_valid never depends combinationally on y_ready.
- y_ready bits other than sel are ignored.
- Wrap-around: ptr 3 -> 0. xfer_count 2^CW-1 -> 0 on the next fire.
- Reset mid-SEND or mid-WAIT_EN discards the held item. No transfer is counted.

Decomposition:
- Package demux4_pkg: state encoding (IDLE=2'd0, WAIT_EN=2'd1, SEND=2'd2) and constant NDEST=4.
- Sub-module rr_pick4: purely combinational cyclic first-set finder.
  - Inputs: start[1:0], mask[3:0].
  - Outputs: idx[1:0], found.
  - Used for both pick(ptr, en) and pick(sel+1, en).
- Top module holds the FSM, buffer, pointer and counter.

Test Plan:
- Rotation: reset, en=4'b1111, y_ready=4'b1111, in_valid=1 with data 0xA0..0xA5 on consecutive cycles → y_valid sequence 0001, 0010, 0100, 1000, 0001, 0010 on consecutive cycles; xfer_count=6; in_ready held at 1.
- Skip disabled: en=4'b1010, y_ready=4'b1111, four items → sel sequence 1, 3, 1, 3; y_valid never 0001 or 0100.
- Backpressure stickiness:
  - Setup: en=4'b1111, item 0x5C committed to sel=2, y_ready=0 for 5 cycles.
  - Required: y_valid=0100 and y_data=0x5C stable, in_ready=0 throughout.
  - Then clear en[2] and raise y_ready[2] → transfer to y_2 completes and ptr becomes 3.
- No destination: en=0, send item 0x33 → state WAIT_EN, y_valid=0, in_ready=0. Set en=4'b0100 → y_valid=0100 one cycle later; y_ready[2]=1 completes it.
- Reset mid-operation: hold item in SEND with y_ready=0, assert reset for 1 cycle → next cycle y_valid=0, busy=0, sel=0, xfer_count=0, in_ready=1 after reset drops.
- Counter wrap: CW=4, 17 transfers with all ready → xfer_count ends at 1.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared state encoding and destination count for the 4-way round-robin dispatcher.
package demux4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_EN = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam int NDEST = 4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational cyclic first-set finder: lowest offset from start whose mask bit is set.
module rr_pick4
  import demux4_pkg::*;
(
  input  logic [1:0]       start,
  input  logic [NDEST-1:0] mask,
  output logic [1:0]       idx,
  output logic             found
);

  logic [2*NDEST-1:0] dbl;
  logic [NDEST-1:0]   rot;
  logic [1:0]         offset;

  // Rotating the doubled mask puts the preferred index at bit 0, so a plain priority encode works.
  assign dbl = {mask, mask};
  assign rot = NDEST'(dbl >> start);

  always_comb begin
    offset = 2'd0;
    found  = 1'b1;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else if (rot[3]) offset = 2'd3;
    else             found  = 1'b0;
  end

  assign idx = start + offset;

endmodule

// File: rtl/demux4_dispatcher.sv
// Holds one item and commits it to an enabled destination in round-robin order,
// keeping the offer sticky until that destination accepts.
module demux4_dispatcher
  import demux4_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NDEST-1:0] en,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [NDEST-1:0] y_valid,
  input  logic [NDEST-1:0] y_ready,
  output logic [W-1:0]     y_data,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CW-1:0]    xfer_count
);

  state_t        state, next_state;
  logic [1:0]    ptr;
  logic [1:0]    next_sel;
  logic [1:0]    sel_plus;
  logic [W-1:0]  buf_data;
  logic          fire;
  logic          load;
  logic [1:0]    ptr_idx, nxt_idx;
  logic          ptr_found, nxt_found;

  assign sel_plus = sel + 2'd1;

  rr_pick4 u_pick_ptr (
    .start (ptr),
    .mask  (en),
    .idx   (ptr_idx),
    .found (ptr_found)
  );

  // Used when a new item is loaded in the same cycle the current one is delivered.
  rr_pick4 u_pick_nxt (
    .start (sel_plus),
    .mask  (en),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    fire       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
          if (ptr_found) begin
            next_sel   = ptr_idx;
            next_state = SEND;
          end else begin
            next_state = WAIT_EN;
          end
        end
      end
      WAIT_EN: begin
        if (ptr_found) begin
          next_sel   = ptr_idx;
          next_state = SEND;
        end
      end
      SEND: begin
        if (y_ready[sel]) begin
          fire = 1'b1;
          if (in_valid) begin
            load = 1'b1;
            if (nxt_found) begin
              next_sel   = nxt_idx;
              next_state = SEND;
            end else begin
              next_state = WAIT_EN;
            end
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 2'd0;
      sel        <= 2'd0;
      buf_data   <= '0;
      xfer_count <= '0;
    end else begin
      sel <= next_sel;
      if (load) buf_data <= in_data;
      if (fire) begin
        ptr        <= sel_plus;
        xfer_count <= xfer_count + CW'(1);
      end
    end
  end

  // in_ready deliberately follows y_ready[sel] combinationally for one item per cycle.
  assign in_ready = !reset && ((state == IDLE) || ((state == SEND) && y_ready[sel]));
  assign y_valid  = (!reset && (state == SEND)) ? (NDEST'(1) << sel) : '0;
  assign y_data   = buf_data;
  assign busy     = !reset && (state != IDLE);

endmodule
